// File: rtl/alu_share_ctrl_if.sv
// Bundle of request, response and ALU-side signals for the shared-ALU controller.
// The slave modport is the controller's view; the master modport belongs to the surrounding logic.
interface alu_share_ctrl_if #(
  parameter int n     = 32,
  parameter int CNT_W = 16
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][n-1:0]   req_opA;
  logic [1:0][n-1:0]   req_opB;
  logic [1:0][3:0]     req_S;
  logic [1:0]          req_M;
  logic [1:0]          req_Cin;

  logic [n-1:0]        alu_opA;
  logic [n-1:0]        alu_opB;
  logic [3:0]          alu_S;
  logic                alu_M;
  logic                alu_Cin;
  logic [n-1:0]        alu_DO;
  logic [3:0]          alu_flags;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [n-1:0]        rsp_DO;
  logic [3:0]          rsp_flags;
  logic                rsp_err;
  logic                busy;
  logic [CNT_W-1:0]    op_cnt;

  modport slave (
    input  req_valid, req_opA, req_opB, req_S, req_M, req_Cin,
    input  alu_DO, alu_flags, rsp_ready,
    output req_ready, alu_opA, alu_opB, alu_S, alu_M, alu_Cin,
    output rsp_valid, rsp_id, rsp_DO, rsp_flags, rsp_err, busy, op_cnt
  );

  modport master (
    output req_valid, req_opA, req_opB, req_S, req_M, req_Cin,
    output alu_DO, alu_flags, rsp_ready,
    input  req_ready, alu_opA, alu_opB, alu_S, alu_M, alu_Cin,
    input  rsp_valid, rsp_id, rsp_DO, rsp_flags, rsp_err, busy, op_cnt
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (drive ALU, capture) -> RESP (hold until taken).
module alu_share_ctrl #(
  parameter int n     = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [n-1:0] opA;
    logic [n-1:0] opB;
    logic [3:0]   S;
    logic         M;
    logic         Cin;
  } op_t;

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic             grant;
  logic             accept;
  logic             rsp_done;
  logic [1:0]       ready;
  op_t              req_op;
  op_t              lat_op;
  logic             lat_id;
  logic             rsp_id_q;
  logic [n-1:0]     rsp_do_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] op_cnt_q;

  // Only add (S=1001,Cin=0) and sub (S=0110,Cin=1) are legal arithmetic codes;
  // logic mode must run with Cin=0.
  function automatic logic op_illegal(input op_t o);
    if (!o.M) return o.Cin;
    return !(({o.S, o.Cin} == 5'b10010) || ({o.S, o.Cin} == 5'b01101));
  endfunction

  always_comb begin
    grant        = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    ready        = 2'b00;
    if ((state == IDLE) && (|bus.req_valid) && !rst)
      ready[grant] = 1'b1;
    accept       = |(ready & bus.req_valid);
    rsp_done     = (state == RESP) && bus.rsp_ready;
    req_op.opA   = bus.req_opA[grant];
    req_op.opB   = bus.req_opB[grant];
    req_op.S     = bus.req_S[grant];
    req_op.M     = bus.req_M[grant];
    req_op.Cin   = bus.req_Cin[grant];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A reset during EXEC/RESP simply discards the in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      lat_op      <= '0;
      lat_id      <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_do_q    <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      if (accept) begin
        lat_op <= req_op;
        lat_id <= grant;
      end
      if (state == EXEC) begin
        rsp_do_q    <= bus.alu_DO;
        rsp_flags_q <= bus.alu_flags;
        rsp_err_q   <= op_illegal(lat_op);
        rsp_id_q    <= lat_id;
      end
      if (rsp_done) begin
        op_cnt_q <= op_cnt_q + CNT_W'(1);
        rr_ptr   <= ~rsp_id_q;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.alu_opA   = lat_op.opA;
  assign bus.alu_opB   = lat_op.opB;
  assign bus.alu_S     = lat_op.S;
  assign bus.alu_M     = lat_op.M;
  assign bus.alu_Cin   = lat_op.Cin;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_DO    = rsp_do_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.op_cnt    = op_cnt_q;

  a_one_ready: assert property (@(posedge clk) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU on the alu_* side, scoreboard of expected
// responses filled on each accepted request and drained on each response.
module tb_alu_share_ctrl;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_share_ctrl_if #(.n(32), .CNT_W(16)) bus ();

  alu_share_ctrl #(.n(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [3:0]  flags;
    logic        err;
    logic [31:0] d;
  } exp_t;

  exp_t sbq[$];
  bit   dual_ready = 1'b0;

  // 74181-flavoured ALU: M=1 arithmetic, M=0 bitwise logic; returns {C,V,N,Z,DO}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s, input logic m, input logic c);
    logic [32:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    if (m) begin
      case (s)
        4'b1001: begin
          r = {1'b0, a} + {1'b0, b} + {32'd0, c};
          v = (a[31] == b[31]) && (r[31] != a[31]);
        end
        4'b0110: begin
          r = {1'b0, a} + {1'b0, ~b} + {32'd0, c};
          v = (a[31] != b[31]) && (r[31] != a[31]);
        end
        default: r = {1'b0, a} + {32'd0, c};
      endcase
    end else begin
      case (s)
        4'b0110: r = {1'b0, a ^ b};
        4'b1011: r = {1'b0, a & b};
        4'b1110: r = {1'b0, a | b};
        default: r = {1'b0, ~a};
      endcase
    end
    return {r[32], v, r[31], (r[31:0] == 32'd0), r[31:0]};
  endfunction

  function automatic exp_t mk_exp(input int i, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] s, input logic m, input logic c);
    exp_t        e;
    logic [35:0] r;
    r       = alu_fn(a, b, s, m, c);
    e.id    = (i != 0);
    e.flags = r[35:32];
    e.d     = r[31:0];
    if (m) e.err = !((s == 4'b1001 && !c) || (s == 4'b0110 && c));
    else   e.err = c;
    return e;
  endfunction

  always_comb {bus.alu_flags, bus.alu_DO} = alu_fn(bus.alu_opA, bus.alu_opB, bus.alu_S, bus.alu_M, bus.alu_Cin);

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sbq.push_back(mk_exp(i, bus.req_opA[i], bus.req_opB[i], bus.req_S[i], bus.req_M[i], bus.req_Cin[i]));
    end
    if (bus.req_ready == 2'b11) dual_ready = 1'b1;
  end

  task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] s, input logic m, input logic c);
    bus.req_opA[i] = a;
    bus.req_opB[i] = b;
    bus.req_S[i]   = s;
    bus.req_M[i]   = m;
    bus.req_Cin[i] = c;
  endtask

  // Returns just after the accepting edge, with that requester's valid dropped.
  task automatic wait_grant(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[i] && bus.req_valid[i]) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.req_valid[i] = 1'b0;
  endtask

  // Returns on the negedge where rsp_valid is first seen.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    total++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL rst_valid_busy got=%b exp=00", {bus.rsp_valid, bus.busy}); end
    total++; if (bus.op_cnt !== 16'd0) begin bad++; $display("FAIL rst_op_cnt got=%0d exp=0", bus.op_cnt); end
    total++; if ({bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO} !== 38'd0) begin bad++; $display("FAIL rst_rsp got=%h exp=0", {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO}); end
    total++; if ({bus.alu_opA, bus.alu_opB, bus.alu_S, bus.alu_M, bus.alu_Cin} !== 70'd0) begin bad++; $display("FAIL rst_alu got=%h exp=0", {bus.alu_opA, bus.alu_opB, bus.alu_S, bus.alu_M, bus.alu_Cin}); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    exp_t obs, e;
    drive_req(0, 32'd5, 32'd3, 4'b1001, 1'b1, 1'b0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b exp=01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    total++; if ({bus.rsp_valid, bus.busy} !== 2'b01) begin bad++; $display("FAIL add_exec got=%b exp=01", {bus.rsp_valid, bus.busy}); end
    total++; if ({bus.alu_opA, bus.alu_opB, bus.alu_S, bus.alu_M, bus.alu_Cin} !== {32'd5, 32'd3, 4'b1001, 1'b1, 1'b0}) begin bad++; $display("FAIL add_alu_drive got=%h exp=%h", {bus.alu_opA, bus.alu_opB, bus.alu_S, bus.alu_M, bus.alu_Cin}, {32'd5, 32'd3, 4'b1001, 1'b1, 1'b0}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL add_latency got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.op_cnt !== 16'd0) begin bad++; $display("FAIL add_cnt_pre got=%0d exp=0", bus.op_cnt); end
    total++; if ({bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO} !== {1'b0, 4'b0000, 1'b0, 32'd8}) begin bad++; $display("FAIL add_const got=%h exp=%h", {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO}, {1'b0, 4'b0000, 1'b0, 32'd8}); end
    obs = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL add_sb got=%h exp=none", obs); end
    else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL add_sb got=%h exp=%h", obs, e); end end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.op_cnt, bus.rsp_valid, bus.busy} !== {16'd1, 2'b00}) begin bad++; $display("FAIL add_cnt_post got=%h exp=%h", {bus.op_cnt, bus.rsp_valid, bus.busy}, {16'd1, 2'b00}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    exp_t obs, e;
    bit   ok;
    drive_req(1, 32'd3, 32'd5, 4'b0110, 1'b1, 1'b1);
    bus.req_valid = 2'b10;
    wait_grant(1, ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_grant got=timeout exp=grant"); end
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_rsp got=timeout exp=rsp_valid"); end
    obs = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
    total++; if (obs !== {1'b1, 4'b0010, 1'b0, 32'hFFFF_FFFE}) begin bad++; $display("FAIL sub_const got=%h exp=%h", obs, {1'b1, 4'b0010, 1'b0, 32'hFFFF_FFFE}); end
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL sub_sb got=%h exp=none", obs); end
    else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL sub_sb got=%h exp=%h", obs, e); end end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.op_cnt !== 16'd2) begin bad++; $display("FAIL sub_cnt got=%0d exp=2", bus.op_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    exp_t        obs, e;
    bit          ok;
    logic [31:0] ta [2] = '{32'h0, 32'h0000_00F0};
    logic [31:0] tb [2] = '{32'h7, 32'h0000_00FF};
    logic [3:0]  ts [2] = '{4'b0000, 4'b0110};
    logic [1:0]  tm [2] = '{2'b11, 2'b01};
    for (int t = 0; t < 2; t++) begin
      drive_req(0, ta[t], tb[t], ts[t], tm[t][1], tm[t][0]);
      bus.req_valid = 2'b01;
      wait_grant(0, ok);
      total++; if (!ok) begin bad++; $display("FAIL ill_grant%0d got=timeout exp=grant", t); end
      wait_rsp(ok);
      total++; if (!ok) begin bad++; $display("FAIL ill_rsp%0d got=timeout exp=rsp_valid", t); end
      obs = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
      total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL ill_err%0d got=%b exp=1", t, bus.rsp_err); end
      if (t == 0) begin
        total++; if (bus.rsp_DO !== 32'h0000_0001) begin bad++; $display("FAIL ill_do got=%h exp=00000001", bus.rsp_DO); end
      end
      total++;
      if (sbq.size() == 0) begin bad++; $display("FAIL ill_sb%0d got=%h exp=none", t, obs); end
      else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL ill_sb%0d got=%h exp=%h", t, obs, e); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    exp_t        obs, now, e;
    bit          ok;
    logic [15:0] cnt0;
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'h7FFF_FFFF, 32'd1, 4'b1001, 1'b1, 1'b0);
    bus.req_valid = 2'b01;
    wait_grant(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_grant got=timeout exp=grant"); end
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_rsp got=timeout exp=rsp_valid"); end
    obs  = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
    cnt0 = bus.op_cnt;
    @(posedge clk); #1;
    // A second requester shows up during the stall and then withdraws.
    drive_req(1, 32'd9, 32'd2, 4'b0110, 1'b1, 1'b1);
    bus.req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      now = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
      total++; if ({now, bus.req_ready, bus.busy, bus.rsp_valid, bus.op_cnt} !== {obs, 2'b00, 2'b11, cnt0}) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", k, {now, bus.req_ready, bus.busy, bus.rsp_valid, bus.op_cnt}, {obs, 2'b00, 2'b11, cnt0}); end
      @(posedge clk); #1;
      if (k == 2) bus.req_valid = 2'b00;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (obs !== {1'b0, 4'b0110, 1'b0, 32'h8000_0000}) begin bad++; $display("FAIL stall_const got=%h exp=%h", obs, {1'b0, 4'b0110, 1'b0, 32'h8000_0000}); end
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL stall_sb got=%h exp=none", obs); end
    else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL stall_sb got=%h exp=%h", obs, e); end end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.op_cnt !== cnt0 + 16'd1) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.op_cnt, cnt0 + 16'd1); end
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if ({bus.busy, 32'(sbq.size())} !== 33'd0) begin bad++; $display("FAIL withdraw_idle got=busy%b q%0d exp=busy0 q0", bus.busy, sbq.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t       obs, e;
    int         grants[$];
    int         gcyc[$];
    int         nrsp;
    logic [3:0] gp;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    dual_ready = 1'b0;
    nrsp = 0;
    drive_req(0, 32'd100, 32'd23, 4'b1001, 1'b1, 1'b0);
    drive_req(1, 32'h0000_F0F0, 32'h0000_FF00, 4'b1011, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
      @(negedge clk);
      if ((bus.req_ready & bus.req_valid) != 2'b00) begin
        grants.push_back(int'(bus.req_ready[1]));
        gcyc.push_back(cyc);
      end
      if (bus.rsp_valid) begin
        nrsp++;
        obs = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL b2b_sb%0d got=%h exp=none", nrsp, obs); end
        else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL b2b_sb%0d got=%h exp=%h", nrsp, obs, e); end end
      end
      @(posedge clk); #1;
      if (grants.size() >= 4) bus.req_valid = 2'b00;
    end
    bus.req_valid = 2'b00;
    gp = '0;
    for (int k = 0; k < 4 && k < grants.size(); k++) gp[k] = (grants[k] != 0);
    total++; if (nrsp !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", nrsp); end
    total++; if (grants.size() != 4 || gp !== 4'b1010) begin bad++; $display("FAIL b2b_order got=n%0d seq%b exp=n4 seq1010", grants.size(), gp); end
    total++; if (gcyc.size() != 4 || (gcyc[3] - gcyc[0]) != 9) begin bad++; $display("FAIL b2b_rate got=n%0d span%0d exp=n4 span9", gcyc.size(), (gcyc.size() == 4) ? gcyc[3] - gcyc[0] : -1); end
    total++; if (dual_ready !== 1'b0) begin bad++; $display("FAIL b2b_dual_ready got=%b exp=0", dual_ready); end
  endtask

  task automatic test_reset_mid();
    exp_t obs, e;
    bit   ok;
    bit   seen;
    // Complete a requester-0 op so the pointer favours requester 1 before the reset.
    drive_req(0, 32'd1, 32'd1, 4'b1001, 1'b1, 1'b0);
    bus.req_valid = 2'b01;
    wait_grant(0, ok);
    wait_rsp(ok);
    obs = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
    total++;
    if (sbq.size() == 0 || !ok) begin bad++; $display("FAIL rm_pre got=%h exp=response", obs); end
    else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL rm_pre got=%h exp=%h", obs, e); end end
    @(posedge clk); #1;
    drive_req(1, 32'd9, 32'd4, 4'b0110, 1'b1, 1'b1);
    bus.req_valid = 2'b10;
    wait_grant(1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_grant got=timeout exp=grant"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    total++; if ({bus.busy, bus.rsp_valid, bus.op_cnt} !== 18'd0) begin bad++; $display("FAIL rm_idle got=%h exp=0", {bus.busy, bus.rsp_valid, bus.op_cnt}); end
    seen = bus.rsp_valid;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_no_rsp got=%b exp=0", seen); end
    @(posedge clk); #1;
    drive_req(0, 32'd2, 32'd2, 4'b1001, 1'b1, 1'b0);
    drive_req(1, 32'd7, 32'd7, 4'b0110, 1'b1, 1'b1);
    bus.req_valid = 2'b11;
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rm_prio got=%b exp=01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_rsp got=timeout exp=rsp_valid"); end
    obs = {bus.rsp_id, bus.rsp_flags, bus.rsp_err, bus.rsp_DO};
    total++; if (obs !== {1'b0, 4'b0000, 1'b0, 32'd4}) begin bad++; $display("FAIL rm_after got=%h exp=%h", obs, {1'b0, 4'b0000, 1'b0, 32'd4}); end
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL rm_sb got=%h exp=none", obs); end
    else begin e = sbq.pop_front(); if (obs !== e) begin bad++; $display("FAIL rm_sb got=%h exp=%h", obs, e); end end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.op_cnt !== 16'd1) begin bad++; $display("FAIL rm_cnt got=%0d exp=1", bus.op_cnt); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_opA   = '0;
    bus.req_opB   = '0;
    bus.req_S     = '0;
    bus.req_M     = '0;
    bus.req_Cin   = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
